// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized active-low rows, debounces whole scans and reports one hex key.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_row_n,
    output logic [3:0] o_col_n,
    output logic [3:0] o_key,
    output logic       o_valid,
    output logic       o_pressed,
    output logic       o_released
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

    logic [3:0]    r_row_s1, r_row_s2;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_col_n;
    logic [15:0]   r_acc;
    logic          r_scan_done;

    state_t        r_state;
    logic [3:0]    r_cand;
    logic [DW-1:0] r_cnt_db;
    logic [3:0]    r_key;
    logic          r_valid, r_pressed, r_released;

    logic [4:0]    w_nbits;
    logic [3:0]    w_code;
    logic          w_single, w_same;
    logic [1:0]    w_next_idx;
    logic [DW-1:0] w_cnt_inc;

    assign w_next_idx = r_col_idx + 2'd1;
    assign w_cnt_inc  = r_cnt_db + DW'(1);

    // Rows come straight off the pins, so they are synchronized before use.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= i_row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_col_idx   <= 2'd0;
            r_col_n     <= 4'b1110;
            r_acc       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                for (int r = 0; r < 4; r++)
                    r_acc[{2'(r), r_col_idx}] <= ~r_row_s2[r];
                r_col_idx <= w_next_idx;
                r_col_n   <= ~(4'b0001 << w_next_idx);
                if (r_col_idx == 2'd3)
                    r_scan_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // More than one key down is treated as ghosting and never matches.
    always_comb begin
        w_nbits = 5'd0;
        w_code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_acc[i]) begin
                w_nbits = w_nbits + 5'd1;
                w_code  = 4'(i);
            end
        end
    end

    assign w_single = (w_nbits == 5'd1);
    assign w_same   = w_single && (w_code == r_cand);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_cand     <= 4'd0;
            r_cnt_db   <= '0;
            r_key      <= 4'd0;
            r_valid    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            if (r_scan_done) begin
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_cand   <= w_code;
                            r_cnt_db <= DW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state   <= HELD;
                                r_key     <= w_code;
                                r_valid   <= 1'b1;
                                r_pressed <= 1'b1;
                            end else begin
                                r_state <= CAND;
                            end
                        end
                    end
                    CAND: begin
                        if (w_same) begin
                            if (w_cnt_inc == DB_LAST) begin
                                r_state   <= HELD;
                                r_key     <= r_cand;
                                r_valid   <= 1'b1;
                                r_pressed <= 1'b1;
                            end
                            r_cnt_db <= w_cnt_inc;
                        end else if (w_single) begin
                            r_cand   <= w_code;
                            r_cnt_db <= DW'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!w_same) begin
                            r_cnt_db <= DW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state    <= IDLE;
                                r_valid    <= 1'b0;
                                r_released <= 1'b1;
                            end else begin
                                r_state <= REL;
                            end
                        end
                    end
                    REL: begin
                        if (w_same) begin
                            r_state <= HELD;
                        end else begin
                            if (w_cnt_inc == DB_LAST) begin
                                r_state    <= IDLE;
                                r_valid    <= 1'b0;
                                r_released <= 1'b1;
                            end
                            r_cnt_db <= w_cnt_inc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_col_n    = r_col_n;
    assign o_key      = r_key;
    assign o_valid    = r_valid;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad on the pins.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       valid, pressed, released;
    logic [15:0] held = 16'h0;

    int errors = 0;
    int checks = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_row_n(row_n), .o_col_n(col_n),
        .o_key(key), .o_valid(valid), .o_pressed(pressed), .o_released(released)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered on a negedge one cycle past a scan boundary; leaves at the same phase.
    task automatic run_scans(input logic [15:0] keys, input int n, output int np,
                             output int nr, output int first_p, output int both);
        held = keys;
        np = 0; nr = 0; first_p = -1; both = 0;
        for (int i = 1; i <= 16*n; i++) begin
            @(negedge clk);
            if (pressed) begin
                np++;
                if (first_p < 0) first_p = i;
            end
            if (released) nr++;
            if (pressed && released) both++;
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          p;
        int          r;
        logic        v;
        logic [3:0]  k;
    } vec_t;

    vec_t vecs[13];
    logic [3:0] col_tab[4];

    initial begin
        int np, nr, fp, both, noise;

        col_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0]  = '{16'h0200, 4, 1, 0, 1'b1, 4'h9};
        vecs[1]  = '{16'h0000, 2, 0, 1, 1'b0, 4'h9};
        vecs[2]  = '{16'h0200, 1, 0, 0, 1'b0, 4'h9};
        vecs[3]  = '{16'h0000, 1, 0, 0, 1'b0, 4'h9};
        vecs[4]  = '{16'h0200, 2, 1, 0, 1'b1, 4'h9};
        vecs[5]  = '{16'h0000, 1, 0, 0, 1'b1, 4'h9};
        vecs[6]  = '{16'h0200, 2, 0, 0, 1'b1, 4'h9};
        vecs[7]  = '{16'h0000, 2, 0, 1, 1'b0, 4'h9};
        vecs[8]  = '{16'h0028, 4, 0, 0, 1'b0, 4'h9};
        vecs[9]  = '{16'h0200, 2, 1, 0, 1'b1, 4'h9};
        vecs[10] = '{16'h0040, 2, 0, 1, 1'b0, 4'h9};
        vecs[11] = '{16'h0040, 2, 1, 0, 1'b1, 4'h6};
        vecs[12] = '{16'h0000, 2, 0, 1, 1'b0, 4'h6};

        repeat (3) @(negedge clk);
        chk("reset_col", col_n, 4'b1110);
        chk("reset_key", key, 4'h0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_pulses", {pressed, released}, 2'b00);
        rst_n = 1'b1;

        noise = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk($sformatf("col_seq_%0d", k), col_n, col_tab[(k/4)%4]);
            if (valid || pressed || released) noise++;
        end
        chk("idle_quiet", noise, 0);
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            run_scans(vecs[v].keys, vecs[v].scans, np, nr, fp, both);
            chk($sformatf("v%0d_pressed", v), np, vecs[v].p);
            chk($sformatf("v%0d_released", v), nr, vecs[v].r);
            chk($sformatf("v%0d_valid", v), valid, vecs[v].v);
            chk($sformatf("v%0d_key", v), key, vecs[v].k);
            chk($sformatf("v%0d_both", v), both, 0);
            if (v == 0) chk("press_latency", fp, 32);
        end

        // Key 0 in the candidate stage, then reset mid-scan on column 1.
        run_scans(16'h0001, 1, np, nr, fp, both);
        repeat (5) @(negedge clk);
        chk("pre_reset_col", col_n, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_col", col_n, 4'b1110);
        chk("async_key", key, 4'h0);
        chk("async_valid", valid, 1'b0);
        chk("async_pulses", {pressed, released}, 2'b00);
        held = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_scans(16'h8000, 2, np, nr, fp, both);
        chk("kF_pressed", np, 1);
        chk("kF_released", nr, 0);
        chk("kF_latency", fp, 32);
        chk("kF_valid", valid, 1'b1);
        chk("kF_key", key, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
